// File: rtl/smc_nominal_model_mc.sv
// Multi-channel nominal-model integrator (semi-implicit Euler, one shared MAC path).
// Optional SMC_NOM_SAT_EN: saturating accumulators plus sticky ovf output.
module smc_nominal_model_mc #(
    parameter int CH         = 2,
    parameter int W          = 32,
    parameter int GAIN_SHIFT = 4,
    parameter int TS         = 5,
    parameter int TS_FRAC    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stop_rst,
    input  logic            start,
    input  logic [CH*W-1:0] u,
    output logic            busy,
    output logic            done,
`ifdef SMC_NOM_SAT_EN
    output logic            ovf,
`endif
    output logic [CH*W-1:0] thetan,
    output logic [CH*W-1:0] dthetan
);

    localparam int IW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int DW  = W + GAIN_SHIFT;
    localparam int TW  = 33;
    localparam int VPW = DW + TW;
    localparam int PPW = W + TW;
    localparam int SW  = VPW + 1;

    localparam logic signed [TW-1:0] TS_S  = TW'(TS);
    localparam logic [W-1:0]         W_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         W_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, VEL, POS, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic [W-1:0]   u_hold [CH];
    logic [W-1:0]   vel_st [CH];
    logic [W-1:0]   pos_st [CH];
    logic [IW-1:0]  idx;
    logic [W-1:0]   vel_new;

    logic signed [W-1:0]   u_cur;
    logic signed [DW-1:0]  ddt_ext;
    logic signed [DW-1:0]  ddt;
    logic signed [VPW-1:0] vprod;
    logic signed [VPW-1:0] vdv;
    logic signed [SW-1:0]  vsum;
    logic signed [PPW-1:0] pprod;
    logic signed [PPW-1:0] pdv;
    logic signed [SW-1:0]  psum;
    logic [W-1:0]          vel_next;
    logic [W-1:0]          pos_next;
    logic                  last_ch;

    // True when the wide sum does not fit in W signed bits
    function automatic logic clip(input logic signed [SW-1:0] x);
        return !((&x[SW-1:W-1]) || !(|x[SW-1:W-1]));
    endfunction

    // Reduce a wide sum to W bits: clamp or wrap
    function automatic logic [W-1:0] sat(input logic signed [SW-1:0] x);
`ifdef SMC_NOM_SAT_EN
        if (clip(x)) return x[SW-1] ? W_MIN : W_MAX;
`endif
        return x[W-1:0];
    endfunction

    // Shared multiply/accumulate path for the current channel
    always_comb begin
        u_cur    = $signed(u_hold[idx]);
        ddt_ext  = DW'(u_cur);
        ddt      = ddt_ext <<< GAIN_SHIFT;
        vprod    = VPW'(ddt) * VPW'(TS_S);
        vdv      = vprod >>> TS_FRAC;
        vsum     = SW'($signed(vel_st[idx])) + SW'(vdv);
        vel_next = sat(vsum);
        pprod    = PPW'($signed(vel_new)) * PPW'(TS_S);
        pdv      = pprod >>> TS_FRAC;
        psum     = SW'($signed(pos_st[idx])) + SW'(pdv);
        pos_next = sat(psum);
        last_ch  = (idx == IW'(CH - 1));
    end

`ifndef SMC_NOM_SAT_EN
    logic unused_hi;
    assign unused_hi = ^{vsum[SW-1:W], psum[SW-1:W]};
`endif

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = VEL;
            VEL: begin
                busy     = 1'b1;
                state_nx = POS;
            end
            POS: begin
                busy     = 1'b1;
                state_nx = last_ch ? DONE : VEL;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
        if (stop_rst) state_nx = IDLE;
    end

    // Channel state, latched inputs and published outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            vel_new <= '0;
            thetan  <= '0;
            dthetan <= '0;
            for (int k = 0; k < CH; k++) begin
                u_hold[k] <= '0;
                vel_st[k] <= '0;
                pos_st[k] <= '0;
            end
        end else if (stop_rst) begin
            idx     <= '0;
            vel_new <= '0;
            thetan  <= '0;
            dthetan <= '0;
            for (int k = 0; k < CH; k++) begin
                u_hold[k] <= '0;
                vel_st[k] <= '0;
                pos_st[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
                        for (int k = 0; k < CH; k++)
                            u_hold[k] <= u[k*W +: W];
                    end
                end
                VEL: vel_new <= vel_next;
                POS: begin
                    vel_st[idx] <= vel_new;
                    pos_st[idx] <= pos_next;
                    if (last_ch) begin
                        for (int k = 0; k < CH; k++) begin
                            if (idx == IW'(k)) begin
                                dthetan[k*W +: W] <= vel_new;
                                thetan[k*W +: W]  <= pos_next;
                            end else begin
                                dthetan[k*W +: W] <= vel_st[k];
                                thetan[k*W +: W]  <= pos_st[k];
                            end
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: ;
            endcase
        end
    end

`ifdef SMC_NOM_SAT_EN
    // Sticky flag set whenever either accumulator clamps
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (stop_rst)
            ovf <= 1'b0;
        else if (state == VEL && clip(vsum))
            ovf <= 1'b1;
        else if (state == POS && clip(psum))
            ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_smc_nominal_model_mc.sv
// Directed bench for smc_nominal_model_mc: vector table plus corner sequences.
// Second instance (CH=1, TS=0xFFFF) covers the overflow / wrap case.
module tb_smc_nominal_model_mc;

    localparam int W  = 32;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            stop_rst;
    logic            start;
    logic [CH*W-1:0] u;
    logic            busy;
    logic            done;
    logic [CH*W-1:0] thetan;
    logic [CH*W-1:0] dthetan;

    logic         start2;
    logic [W-1:0] u2;
    logic         busy2;
    logic         done2;
    logic [W-1:0] th2;
    logic [W-1:0] dth2;
`ifdef SMC_NOM_SAT_EN
    logic ovf;
    logic ovf2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    smc_nominal_model_mc #(.CH(CH), .W(W)) dut (
        .clk(clk), .rst(rst), .stop_rst(stop_rst), .start(start), .u(u),
        .busy(busy), .done(done),
`ifdef SMC_NOM_SAT_EN
        .ovf(ovf),
`endif
        .thetan(thetan), .dthetan(dthetan)
    );

    smc_nominal_model_mc #(.CH(1), .W(W), .TS(65535)) dut2 (
        .clk(clk), .rst(rst), .stop_rst(1'b0), .start(start2), .u(u2),
        .busy(busy2), .done(done2),
`ifdef SMC_NOM_SAT_EN
        .ovf(ovf2),
`endif
        .thetan(th2), .dthetan(dth2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [31:0] u0;
        logic [31:0] u1;
        logic [31:0] v0;
        logic [31:0] p0;
        logic [31:0] v1;
        logic [31:0] p1;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        stop_rst = 1'b1;
        @(negedge clk);
        stop_rst = 1'b0;
    endtask

    // lat = cycle index (start edge = cycle 0 sample) where done seen, -1 if never
    task automatic run_step(input logic [CH*W-1:0] uv, output int lat,
                            output int bz_err);
        bit seen;
        @(negedge clk);
        u     = uv;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        u      = {$urandom, $urandom};
        lat    = 0;
        bz_err = 0;
        seen   = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                lat  = c;
                seen = 1;
                if (busy) bz_err++;
                break;
            end
            if (!busy) bz_err++;
            @(negedge clk);
        end
        if (!seen) lat = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bz, nd, lat_err;
        tv[0] = '{1'b1, 32'h00010000, 32'h00000000,
                  32'h00000050, 32'h00000000, 32'h00000000, 32'h00000000};
        tv[1] = '{1'b0, 32'h00010000, 32'hFFFF0000,
                  32'h000000A0, 32'h00000000, 32'hFFFFFFB0, 32'hFFFFFFFF};
        tv[2] = '{1'b0, 32'h00000000, 32'h00020000,
                  32'h000000A0, 32'h00000000, 32'h00000050, 32'hFFFFFFFF};
        tv[3] = '{1'b1, 32'hFFFF0000, 32'h00000000,
                  32'hFFFFFFB0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        tv[4] = '{1'b1, 32'h7FFF0000, 32'h00000000,
                  32'h0027FFB0, 32'h000000C7, 32'h00000000, 32'h00000000};
        tv[5] = '{1'b1, 32'h00000001, 32'h80000000,
                  32'h00000000, 32'h00000000, 32'hFFD80000, 32'hFFFFFF38};

        rst = 1'b1; stop_rst = 1'b0; start = 1'b0; u = '0;
        start2 = 1'b0; u2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_thetan", thetan, 64'd0);
        chk("rst_dthetan", dthetan, 64'd0);
`ifdef SMC_NOM_SAT_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            if (tv[i].clr) do_clear();
            run_step({tv[i].u1, tv[i].u0}, lat, bz);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
            chk($sformatf("v%0d_busy", i), 64'(bz), 64'd0);
            chk($sformatf("v%0d_dthetan0", i), 64'(dthetan[31:0]), 64'(tv[i].v0));
            chk($sformatf("v%0d_thetan0", i), 64'(thetan[31:0]), 64'(tv[i].p0));
            chk($sformatf("v%0d_dthetan1", i), 64'(dthetan[63:32]), 64'(tv[i].v1));
            chk($sformatf("v%0d_thetan1", i), 64'(thetan[63:32]), 64'(tv[i].p1));
        end

        // 164 consecutive steps
        do_clear();
        lat_err = 0;
        for (int n = 1; n <= 164; n++) begin
            run_step({32'h0, 32'h00010000}, lat, bz);
            if (lat != 5 || bz != 0) lat_err++;
            if (n == 163) begin
                chk("s163_dthetan0", 64'(dthetan[31:0]), 64'd13040);
                chk("s163_thetan0", 64'(thetan[31:0]), 64'd0);
            end
            if (n == 164) begin
                chk("s164_dthetan0", 64'(dthetan[31:0]), 64'd13120);
                chk("s164_thetan0", 64'(thetan[31:0]), 64'd1);
            end
        end
        chk("s164_timing_errs", 64'(lat_err), 64'd0);
        repeat (6) @(negedge clk);
        chk("hold_dthetan0", 64'(dthetan[31:0]), 64'd13120);
        chk("hold_thetan0", 64'(thetan[31:0]), 64'd1);

        // Second start while busy is ignored
        do_clear();
        nd = 0;
        @(negedge clk);
        u = {32'h0, 32'h00010000};
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = (c == 2);
            if (done) nd++;
        end
        start = 1'b0;
        chk("rebusy_dones", 64'(nd), 64'd1);
        chk("rebusy_dthetan0", 64'(dthetan[31:0]), 64'h50);
        chk("rebusy_thetan", thetan, 64'd0);

        // stop_rst during POS of channel 0
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        stop_rst = 1'b1;
        @(negedge clk);
        stop_rst = 1'b0;
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_dthetan", dthetan, 64'd0);
        chk("stop_thetan", thetan, 64'd0);
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("stop_dones", 64'(nd), 64'd0);

        // start and stop_rst together from IDLE
        u = {32'h00010000, 32'h00010000};
        start = 1'b1;
        stop_rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop_rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        chk("both_activity", 64'(nd), 64'd0);
        chk("both_dthetan", dthetan, 64'd0);

        // Async rst mid-step
        run_step({32'h0, 32'h00010000}, lat, bz);
        chk("prerst_dthetan0", 64'(dthetan[31:0]), 64'h50);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_dthetan", dthetan, 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("arst_dones", 64'(nd), 64'd0);

        // Overflow instance: TS=0xFFFF, u=0x7FFFFFFF
        u2 = 32'h7FFFFFFF;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        u2 = '0;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            if (done2) begin
                nd = 1;
                break;
            end
            @(negedge clk);
        end
        chk("ovf_done_seen", 64'(nd), 64'd1);
`ifdef SMC_NOM_SAT_EN
        chk("sat_dthetan0", 64'(dth2), 64'h7FFFFFFF);
        chk("sat_thetan0", 64'(th2), 64'h7FFF7FFF);
        chk("sat_ovf", 64'(ovf2), 64'd1);
`else
        chk("wrap_dthetan0", 64'(dth2), 64'hFFF7FFF0);
        chk("wrap_thetan0", 64'(th2), 64'hFFF7FFF8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
